// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
// Optional round-robin policy is selected by defining MEM_ARBITER_RR_EN.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int unsigned DefAddrW     = 32;
  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefStarveMax = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// prefer_fetch_i carries the policy decision (starvation flag or round-robin pointer).
module mem_arb_pick (
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic prefer_fetch_i,
  output logic i_win_o,
  output logic d_win_o
);

  always_comb begin
    i_win_o = 1'b0;
    d_win_o = 1'b0;
    if (i_req_i && d_req_i) begin
      i_win_o = prefer_fetch_i;
      d_win_o = ~prefer_fetch_i;
    end else begin
      i_win_o = i_req_i;
      d_win_o = d_req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one synchronous single-port RAM.
// Define MEM_ARBITER_RR_EN for round-robin; otherwise data has priority with fetch anti-starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned STARVE_MAX = DefStarveMax
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic   rd_pending_q, rd_pending_d;
  owner_e resp_owner_q, resp_owner_d;
  logic   prefer_fetch;
  logic   i_win, d_win;

`ifdef MEM_ARBITER_RR_EN
  owner_e rr_ptr_q, rr_ptr_d;

  assign prefer_fetch = (rr_ptr_q == OWNER_FETCH);

  // Pointer always hands preference to whoever did not just win.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (i_gnt) begin
      rr_ptr_d = OWNER_DATA;
    end else if (d_gnt) begin
      rr_ptr_d = OWNER_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= OWNER_FETCH;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            starved;

  assign starved      = (starve_cnt_q == CntW'(STARVE_MAX));
  assign prefer_fetch = starved;

  // Counts consecutive lost fetch arbitrations; saturates at STARVE_MAX.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_gnt) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  mem_arb_pick u_pick (
    .i_req_i        (i_req),
    .d_req_i        (d_req),
    .prefer_fetch_i (prefer_fetch),
    .i_win_o        (i_win),
    .d_win_o        (d_win)
  );

  // Grants are suppressed while reset is held so the RAM sees no command.
  always_comb begin
    i_gnt     = i_win & rst_n;
    d_gnt     = d_win & rst_n;
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
    end else if (i_gnt) begin
      mem_addr = i_addr;
    end
  end

  always_comb begin
    rd_pending_d = i_gnt | (d_gnt & ~d_we);
    resp_owner_d = resp_owner_q;
    if (d_gnt && !d_we) begin
      resp_owner_d = OWNER_DATA;
    end else if (i_gnt) begin
      resp_owner_d = OWNER_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pending_q <= 1'b0;
      resp_owner_q <= OWNER_FETCH;
    end else begin
      rd_pending_q <= rd_pending_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // Gating with rst_n drops a read whose response would land during reset.
  always_comb begin
    i_rvalid = rst_n & rd_pending_q & (resp_owner_q == OWNER_FETCH);
    d_rvalid = rst_n & rd_pending_q & (resp_owner_q == OWNER_DATA);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a read-response scoreboard.
// Adapts its contention expectations when MEM_ARBITER_RR_EN is defined.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_i[$];
  logic [31:0] q_d[$];

  logic [31:0] ram [0:15] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h00000013, 32'h0, 32'h0, 32'h0,
                              32'hCAFE0008, 32'h11223344, 32'h0A0A0A0A, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0};

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  // Synchronous single-port RAM model with byte strobes.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) ram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr[5:2]];
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rvalid must match the oldest outstanding expected read.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (i_rvalid === 1'b1) begin
      if (q_i.size() == 0) chk1("i_rvalid_unexpected", i_rvalid, 1'b0);
      else begin
        exp = q_i.pop_front();
        chk32("i_rdata", i_rdata, exp);
      end
    end else chk32("i_rdata_idle", i_rdata, 32'h0);
    if (d_rvalid === 1'b1) begin
      if (q_d.size() == 0) chk1("d_rvalid_unexpected", d_rvalid, 1'b0);
      else begin
        exp = q_d.pop_front();
        chk32("d_rdata", d_rdata, exp);
      end
    end else chk32("d_rdata_idle", d_rdata, 32'h0);
  end

  initial begin
    logic exp_f;
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = '0; d_wstrb = '0;

    // Reset hold with both requests active.
    repeat (3) begin
      @(negedge clk);
      chk1("rst_i_gnt", i_gnt, 1'b0);
      chk1("rst_d_gnt", d_gnt, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk1("first_i_gnt", i_gnt, RrEn);
    chk1("first_d_gnt", d_gnt, !RrEn);
    if (RrEn) q_i.push_back(32'h00000013); else q_d.push_back(32'hCAFE0008);
    next_cycle();
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk1("first_rvalid", RrEn ? i_rvalid : d_rvalid, 1'b1);

    // Idle outputs.
    chk1("idle_mem_en", mem_en, 1'b0);
    chk1("idle_mem_we", mem_we, 1'b0);
    chk32("idle_mem_addr", mem_addr, 32'h0);
    chk32("idle_mem_wdata", mem_wdata, 32'h0);
    chk32("idle_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    next_cycle();

    // Lone fetch.
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk1("fetch_i_gnt", i_gnt, 1'b1);
    chk1("fetch_d_gnt", d_gnt, 1'b0);
    chk1("fetch_mem_en", mem_en, 1'b1);
    chk32("fetch_mem_addr", mem_addr, 32'h10);
    q_i.push_back(32'h00000013);
    next_cycle();
    i_req = 1'b0;
    @(negedge clk);
    chk1("fetch_i_rvalid", i_rvalid, 1'b1);
    next_cycle();

    // Partial store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h0000BEEF; d_wstrb = 4'b0011;
    @(negedge clk);
    chk1("store_d_gnt", d_gnt, 1'b1);
    chk1("store_mem_we", mem_we, 1'b1);
    chk32("store_mem_wstrb", {28'h0, mem_wstrb}, 32'h3);
    chk32("store_mem_addr", mem_addr, 32'h24);
    chk32("store_mem_wdata", mem_wdata, 32'h0000BEEF);
    next_cycle();
    d_we = 1'b0; d_req = 1'b1; d_addr = 32'h24; d_wstrb = '0; d_wdata = '0;

    // Back-to-back loads, first reads back the merged store.
    @(negedge clk);
    chk1("store_no_rvalid", d_rvalid, 1'b0);
    chk1("load0_d_gnt", d_gnt, 1'b1);
    chk1("load0_mem_we", mem_we, 1'b0);
    q_d.push_back(32'h1122BEEF);
    next_cycle();
    d_addr = 32'h28;
    @(negedge clk);
    chk1("load1_d_gnt", d_gnt, 1'b1);
    chk1("load0_d_rvalid", d_rvalid, 1'b1);
    q_d.push_back(32'h0A0A0A0A);
    next_cycle();
    d_req = 1'b0;
    @(negedge clk);
    chk1("load1_d_rvalid", d_rvalid, 1'b1);
    next_cycle();

    // Reset arrives the cycle after a granted load; its response must vanish.
    d_req = 1'b1; d_addr = 32'h20;
    @(negedge clk);
    chk1("rstmid_d_gnt", d_gnt, 1'b1);
    next_cycle();
    rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk1("rstmid_d_rvalid", d_rvalid, 1'b0);
    chk1("rstmid_mem_en", mem_en, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rstmid_after_d_rvalid", d_rvalid, 1'b0);
    next_cycle();

    // Sustained contention straight out of the reset above.
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      exp_f = RrEn ? (k % 2 == 0) : (k % 5 == 4);
      @(negedge clk);
      chk1("cont_i_gnt", i_gnt, exp_f);
      chk1("cont_d_gnt", d_gnt, !exp_f);
      chk32("cont_mem_addr", mem_addr, exp_f ? 32'h10 : 32'h20);
      if (exp_f) q_i.push_back(32'h00000013); else q_d.push_back(32'hCAFE0008);
      next_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk32("sb_i_drained", 32'(q_i.size()), 32'h0);
    chk32("sb_d_drained", 32'(q_d.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
